// File: rtl/threshold_crossing_detector_pkg.sv
// rtl/threshold_crossing_detector_pkg.sv - shared region encoding for the threshold crossing detector
package threshold_crossing_detector_pkg;

    typedef logic [1:0] region_t;

    localparam region_t REG_IDLE = 2'b00;
    localparam region_t REG_LOW  = 2'b01;
    localparam region_t REG_MID  = 2'b10;
    localparam region_t REG_HIGH = 2'b11;

endpackage

// File: rtl/threshold_crossing_detector_mag_cmp.sv
// rtl/threshold_crossing_detector_mag_cmp.sv - unsigned N-bit magnitude comparator (lesser/equal/greater)
module magnitude_compare #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule

// File: rtl/threshold_crossing_detector_region_classify.sv
// rtl/threshold_crossing_detector_region_classify.sv - combinational sample classification against two thresholds
module region_classify
    import threshold_crossing_detector_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] thr_lo,
    input  logic [WIDTH-1:0] thr_hi,
    output region_t          cls
);

    logic lo_lt, lo_eq, lo_gt;
    logic hi_lt, hi_eq, hi_gt;

    magnitude_compare #(.WIDTH(WIDTH)) u_cmp_lo (
        .a  (sample),
        .b  (thr_lo),
        .lt (lo_lt),
        .eq (lo_eq),
        .gt (lo_gt)
    );

    magnitude_compare #(.WIDTH(WIDTH)) u_cmp_hi (
        .a  (sample),
        .b  (thr_hi),
        .lt (hi_lt),
        .eq (hi_eq),
        .gt (hi_gt)
    );

    // Below low is LOW, above high is HIGH; anything inside the band, edges included, is MID
    always_comb begin
        cls = REG_MID;
        if (lo_lt) begin
            cls = REG_LOW;
        end else if (hi_gt) begin
            cls = REG_HIGH;
        end else if ((lo_gt | lo_eq) & (hi_lt | hi_eq)) begin
            cls = REG_MID;
        end
    end

endmodule

// File: rtl/threshold_crossing_detector.sv
// rtl/threshold_crossing_detector.sv - debounced hysteresis region tracker with crossing pulses and event counters
module threshold_crossing_detector
    import threshold_crossing_detector_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] thr_lo_in,
    input  logic [WIDTH-1:0] thr_hi_in,
    input  logic             cnt_clear,
    output logic [1:0]       region,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] fall_count,
    output logic             cfg_error
);

    localparam int              DW       = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] thr_lo_q, thr_lo_d;
    logic [WIDTH-1:0] thr_hi_q, thr_hi_d;
    region_t          region_q, region_d;
    region_t          cand_q, cand_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;

    region_t          cls;
    logic [DW-1:0]    dcnt_inc;

    region_classify #(.WIDTH(WIDTH)) u_classify (
        .sample (sample),
        .thr_lo (thr_lo_q),
        .thr_hi (thr_hi_q),
        .cls    (cls)
    );

    // Config validation, debounce/candidate tracking, region FSM, pulses and saturating counters
    always_comb begin
        thr_lo_d   = thr_lo_q;
        thr_hi_d   = thr_hi_q;
        region_d   = region_q;
        cand_d     = cand_q;
        dcnt_d     = dcnt_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        cfg_err_d  = 1'b0;
        dcnt_inc   = '0;
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;

        if (cfg_load) begin
            // A coincident sample is dropped whether or not the load is accepted
            if (thr_lo_in <= thr_hi_in) begin
                thr_lo_d = thr_lo_in;
                thr_hi_d = thr_hi_in;
                region_d = REG_IDLE;
                dcnt_d   = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            if (region_q == REG_IDLE) begin
                region_d = cls;
                dcnt_d   = '0;
            end else if (cls == region_q) begin
                dcnt_d = '0;
            end else begin
                // A zero count means no candidate is pending, so a stale cand_q never extends a run
                dcnt_inc = ((dcnt_q != '0) && (cls == cand_q)) ? dcnt_q + 1'b1 : DW'(1);
                cand_d   = cls;
                if (dcnt_inc == DEB_LAST) begin
                    region_d = cls;
                    dcnt_d   = '0;
                    rise_d   = (cls == REG_HIGH);
                    fall_d   = (cls == REG_LOW);
                end else begin
                    dcnt_d = dcnt_inc;
                end
            end
        end

        if (cnt_clear) begin
            rise_cnt_d = '0;
            fall_cnt_d = '0;
        end else begin
            if (rise_d && (rise_cnt_q != CNT_MAX)) begin
                rise_cnt_d = rise_cnt_q + 1'b1;
            end
            if (fall_d && (fall_cnt_q != CNT_MAX)) begin
                fall_cnt_d = fall_cnt_q + 1'b1;
            end
        end
    end

    // State register with synchronous reset taking priority over all inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_lo_q   <= '0;
            thr_hi_q   <= '1;
            region_q   <= REG_IDLE;
            cand_q     <= REG_IDLE;
            dcnt_q     <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            rise_cnt_q <= '0;
            fall_cnt_q <= '0;
        end else begin
            thr_lo_q   <= thr_lo_d;
            thr_hi_q   <= thr_hi_d;
            region_q   <= region_d;
            cand_q     <= cand_d;
            dcnt_q     <= dcnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            cfg_err_q  <= cfg_err_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
        end
    end

    assign region     = region_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign rise_count = rise_cnt_q;
    assign fall_count = fall_cnt_q;
    assign cfg_error  = cfg_err_q;

endmodule

// File: tb/tb_threshold_crossing_detector.sv
// tb/tb_threshold_crossing_detector.sv - self-checking bench for threshold_crossing_detector
module tb_threshold_crossing_detector;

    localparam int W   = 8;
    localparam int DEB = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] sample;
    logic         cfg_load;
    logic [W-1:0] thr_lo_in;
    logic [W-1:0] thr_hi_in;
    logic         cnt_clear;

    logic [1:0]   region, region2;
    logic         rise_pulse, fall_pulse, cfg_error;
    logic         rise_pulse2, fall_pulse2, cfg_error2;
    logic [7:0]   rise_count, fall_count;
    logic [1:0]   rise_count2, fall_count2;

    int checks = 0;
    int errors = 0;

    // Reference model state: regions as integers 0..3, counts as unbounded ints clamped on update
    int  m_reg, m_cand, m_cnt, m_tlo, m_thi;
    int  m_rc, m_fc, m_rc2, m_fc2;
    bit  m_rp, m_fp, m_ce;

    always #5 clk = ~clk;

    threshold_crossing_detector #(.WIDTH(W), .DEBOUNCE(DEB), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .sample     (sample),
        .cfg_load   (cfg_load),
        .thr_lo_in  (thr_lo_in),
        .thr_hi_in  (thr_hi_in),
        .cnt_clear  (cnt_clear),
        .region     (region),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .rise_count (rise_count),
        .fall_count (fall_count),
        .cfg_error  (cfg_error)
    );

    threshold_crossing_detector #(.WIDTH(W), .DEBOUNCE(DEB), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .sample     (sample),
        .cfg_load   (cfg_load),
        .thr_lo_in  (thr_lo_in),
        .thr_hi_in  (thr_hi_in),
        .cnt_clear  (cnt_clear),
        .region     (region2),
        .rise_pulse (rise_pulse2),
        .fall_pulse (fall_pulse2),
        .rise_count (rise_count2),
        .fall_count (fall_count2),
        .cfg_error  (cfg_error2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int class_of(input int s);
        if (s < m_tlo) return 1;
        if (s > m_thi) return 3;
        return 2;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_reg = 0; m_cand = 0; m_cnt = 0; m_tlo = 0; m_thi = 255;
        m_rc = 0; m_fc = 0; m_rc2 = 0; m_fc2 = 0;
        m_rp = 0; m_fp = 0; m_ce = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input int s, input bit cl,
                              input int lo, input int hi, input bit clr);
        int c;
        if (r) begin
            model_reset();
            return;
        end
        m_rp = 0; m_fp = 0; m_ce = 0;
        if (cl) begin
            if (lo <= hi) begin
                m_tlo = lo; m_thi = hi; m_reg = 0; m_cnt = 0;
            end else begin
                m_ce = 1;
            end
        end else if (v) begin
            c = class_of(s);
            if (m_reg == 0) begin
                m_reg = c; m_cnt = 0;
            end else if (c == m_reg) begin
                m_cnt = 0;
            end else begin
                m_cnt  = (m_cnt > 0 && c == m_cand) ? m_cnt + 1 : 1;
                m_cand = c;
                if (m_cnt == DEB) begin
                    m_reg = c; m_cnt = 0;
                    m_rp = (c == 3);
                    m_fp = (c == 1);
                end
            end
        end
        if (clr) begin
            m_rc = 0; m_fc = 0; m_rc2 = 0; m_fc2 = 0;
        end else begin
            if (m_rp) begin m_rc = sat_inc(m_rc, 255); m_rc2 = sat_inc(m_rc2, 3); end
            if (m_fp) begin m_fc = sat_inc(m_fc, 255); m_fc2 = sat_inc(m_fc2, 3); end
        end
    endtask

    task automatic step(input bit r, input bit v, input int s, input bit cl,
                        input int lo, input int hi, input bit clr);
        @(negedge clk);
        rst = r; in_valid = v; sample = 8'(s); cfg_load = cl;
        thr_lo_in = 8'(lo); thr_hi_in = 8'(hi); cnt_clear = clr;
        @(posedge clk);
        model_step(r, v, s, cl, lo, hi, clr);
        #1;
        chk("region",      region,      m_reg);
        chk("rise_pulse",  rise_pulse,  m_rp);
        chk("fall_pulse",  fall_pulse,  m_fp);
        chk("rise_count",  rise_count,  m_rc);
        chk("fall_count",  fall_count,  m_fc);
        chk("cfg_error",   cfg_error,   m_ce);
        chk("region_w2",   region2,     m_reg);
        chk("rise_cnt_w2", rise_count2, m_rc2);
        chk("fall_cnt_w2", fall_count2, m_fc2);
    endtask

    task automatic samp(input int s);
        step(0, 1, s, 0, 0, 0, 0);
    endtask

    task automatic gap();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int lo, input int hi);
        step(0, 0, 0, 1, lo, hi, 0);
    endtask

    initial begin
        rst = 1; in_valid = 0; sample = '0; cfg_load = 0;
        thr_lo_in = '0; thr_hi_in = '0; cnt_clear = 0;
        model_reset();

        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_region", region, 0);
        chk("reset_rise_count", rise_count, 0);

        cfg(40, 60);
        samp(50);
        chk("first_sample_mid", region, 2);
        chk("first_sample_nopulse", rise_pulse | fall_pulse, 0);
        samp(40);
        samp(60);
        chk("edges_are_mid", region, 2);

        samp(61); samp(61);
        chk("no_rise_before_third", rise_pulse, 0);
        samp(61);
        chk("rise_on_third", rise_pulse, 1);
        chk("region_high", region, 3);
        chk("rise_count_1", rise_count, 1);
        gap();
        chk("rise_one_cycle", rise_pulse, 0);

        samp(39); samp(39); samp(50); samp(39);
        chk("candidate_restart_holds_high", region, 3);

        samp(39); samp(39);
        chk("fall_to_low", region, 1);
        chk("fall_count_1", fall_count, 1);

        samp(61);
        for (int i = 0; i < 5; i++) gap();
        samp(61);
        chk("invalid_holds_count", region, 1);
        samp(61);
        chk("rise_after_gap", rise_pulse, 1);
        chk("region_high_after_gap", region, 3);

        cfg(70, 30);
        chk("cfg_reject_error", cfg_error, 1);
        chk("cfg_reject_region", region, 3);
        gap();
        chk("cfg_error_one_cycle", cfg_error, 0);
        samp(61);
        chk("thresholds_kept", region, 3);

        step(0, 1, 5, 1, 10, 20, 0);
        chk("cfg_accept_idle", region, 0);

        samp(61); samp(5); samp(5);
        step(1, 1, 5, 0, 0, 0, 0);
        chk("reset_mid_region", region, 0);
        chk("reset_mid_rise_count", rise_count, 0);
        chk("reset_mid_fall_count", fall_count, 0);

        cfg(40, 60);
        samp(39);
        for (int k = 0; k < 4; k++) begin
            samp(61); samp(61); samp(61);
            samp(39); samp(39); samp(39);
        end
        chk("sat_rise_w2", rise_count2, 3);
        chk("nosat_rise_w8", rise_count, 4);
        samp(61); samp(61);
        step(0, 1, 61, 0, 0, 0, 1);
        chk("clear_with_rise_pulse", rise_pulse2, 1);
        chk("clear_with_rise_count", rise_count2, 0);

        for (int n = 0; n < 800; n++) begin
            int  r, s, lo, hi;
            bit  br, bv, bc, bclr;
            r    = $urandom_range(0, 99);
            br   = (r == 0);
            bc   = (r >= 1 && r <= 3);
            bclr = ($urandom_range(0, 49) == 0);
            bv   = ($urandom_range(0, 3) != 0);
            lo   = $urandom_range(0, 255);
            hi   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255)
                                               : $urandom_range(lo, 255);
            s    = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255)
                                               : (m_tlo + $urandom_range(0, 4) - 2);
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            step(br, bv, s, bc, lo, hi, bclr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/threshold_crossing_detector.md
# threshold_crossing_detector

Streaming stage that sits directly downstream of the N-bit magnitude comparator. It compares each valid sample against programmable low and high thresholds using the comparator's lesser/equal/greater outputs. A debounced hysteresis state machine tracks the sample's region. On each debounced region change the block emits single-cycle rise and fall pulses and keeps saturating event counts for the control logic.

## Interface
- WIDTH, 8, sample and threshold width
- DEBOUNCE, 3, consecutive valid samples in a new region required before a transition (≥1)
- CNT_W, 8, width of each event counter

- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  sample qualifier
- sample  in  WIDTH  unsigned sample
- cfg_load  in  1  load thr_lo_in/thr_hi_in this cycle
- thr_lo_in  in  WIDTH  candidate low threshold
- thr_hi_in  in  WIDTH  candidate high threshold
- cnt_clear  in  1  zero both counters
- region  out  2  current state: IDLE=00, LOW=01, MID=10, HIGH=11
- rise_pulse  out  1  one-cycle pulse on entry to HIGH
- fall_pulse  out  1  one-cycle pulse on entry to LOW
- rise_count  out  CNT_W  saturating count of rise events
- fall_count  out  CNT_W  saturating count of fall events
- cfg_error  out  1  one-cycle pulse when a cfg_load is rejected

## Operation
- Reset values:
  - thr_lo=0, thr_hi=all-ones
  - region=IDLE, debounce count=0
  - all pulses 0, both counts 0
- Classification of each valid sample (unsigned):
  - sample < thr_lo → LOW
  - sample > thr_hi → HIGH
  - otherwise → MID; a sample equal to either threshold is MID
- Transitions out of IDLE: the first valid sample sets region to its class immediately, with no debounce and no pulse.
- Transitions in LOW, MID or HIGH:
  - Candidate class equals the current region → debounce count clears to 0.
  - Candidate differs from the current region and matches the previous candidate → count increments.
  - Candidate differs and is a new candidate → count restarts at 1.
  - When the count reaches DEBOUNCE, region takes the candidate class and the count clears.
- Pulses:
  - Entry to HIGH from LOW or MID → rise_pulse, and rise_count increments.
  - Entry to LOW from HIGH or MID → fall_pulse, and fall_count increments.
  - Entry to MID → no pulse.
  - A direct LOW↔HIGH transition is legal and pulses normally.
- in_valid low: region, debounce count and candidate all hold.
- Configuration:
  - cfg_load with thr_lo_in ≤ thr_hi_in → thresholds update, region returns to IDLE, debounce count clears.
  - cfg_load with thr_lo_in > thr_hi_in → rejected: cfg_error pulses, and thresholds and state are unchanged.
- Counters saturate at 2^CNT_W−1.
- cnt_clear:
  - Forces both counters to 0.
  - cnt_clear coincident with an event: count ends at 0; the pulse is still emitted.

## Timing
- All outputs are registered. A sample presented at edge N is reflected in region, pulses and counts after edge N (1-cycle latency).
- Pulses are exactly one cycle wide and are never asserted on consecutive cycles for the same region.
- cfg_load coincident with in_valid: configuration wins and the sample is dropped (no classification, no debounce update).
- rst has priority over every input, including mid-debounce. The cycle after rst, all outputs are at their reset values.
- Thresholds take effect for samples presented on the cycle after an accepted load.

## Structure
- Shared package holds:
  - region encoding localparams (REG_IDLE, REG_LOW, REG_MID, REG_HIGH)
  - the 2-bit region type
- One sub-module, `region_classify`: combinational. It instantiates two magnitude compares (sample vs thr_lo, sample vs thr_hi) and returns the 2-bit class.
- Top-level holds:
  - threshold registers with config validation
  - the debounce counter and candidate register
  - the region FSM
  - pulse registers and saturating counters

## Test plan
All scenarios use WIDTH=8, DEBOUNCE=3, thr_lo=40, thr_hi=60 unless stated.
- Reset applied mid-stream → region=00, both counts 0, no pulses the following cycle.
- First valid sample 50 → region=MID after 1 cycle, no pulse; samples 40 and 60 keep region=MID.
- Samples 61,61,61 → rise_pulse one cycle after the third sample, region=HIGH, rise_count=1; then 39,39,50,39 → no transition (candidate restarted).
- Samples 61, then in_valid low for 5 cycles, then 61,61 → transition after the final 61 (count held while invalid).
- cfg_load lo=70 hi=30 → cfg_error=1 for one cycle, region and thresholds unchanged; cfg_load lo=10 hi=20 → region=IDLE.
- CNT_W=2, force 4 rise events → rise_count stays 3; cnt_clear coincident with the 5th rise → rise_pulse=1, rise_count=0.
